// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, requests words from imem and
// presents instruction/PC pairs to IF/ID through a one-entry output buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_F,
  output logic [31:0] pc_F,
  output logic        valid_F,
  output logic        adel_F
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } st_e;

  st_e st_q, st_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ins_q, ins_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            valid_q, valid_d;
  logic            adel_q, adel_d;

  logic room;
  logic misal;
  logic run;
  logic fire;
  logic adel_load;
  logic drain;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_BOOT;
    else     st_q <= st_d;
  end

  // FSM next state: BOOT lasts one cycle, RUN is left only by reset
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_BOOT: st_d = ST_RUN;
      ST_RUN:  st_d = ST_RUN;
      default: st_d = ST_BOOT;
    endcase
  end

  // FSM outputs: the request is non-binding until imem_ready accepts it
  always_comb begin
    run      = (st_q == ST_RUN) && !rst;
    imem_req = run && room && !redirect && !misal;
  end

  assign room      = !valid_q || !stall;
  assign misal     = (pc_q[1:0] != 2'b00);
  assign fire      = imem_req && imem_ready;
  assign adel_load = run && room && !redirect && misal;
  assign drain     = valid_q && !stall;
  assign imem_addr = pc_q;

  // Buffer and PC update; redirect outranks stall and any in-flight response
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    pc_f_d  = pc_f_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      ins_d   = '0;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (fire) begin
      ins_d   = imem_rdata;
      pc_f_d  = pc_q;
      valid_d = 1'b1;
      adel_d  = 1'b0;
      pc_d    = pc_q + XLEN'(4);
    end else if (adel_load) begin
      // Parked on a misaligned PC: keep re-issuing the ADEL entry
      ins_d   = '0;
      pc_f_d  = pc_q;
      valid_d = 1'b1;
      adel_d  = 1'b1;
    end else if (drain) begin
      ins_d   = '0;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      pc_f_q  <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pc_f_q  <= pc_f_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign ins_F   = ins_q;
  assign pc_F    = pc_f_q;
  assign valid_F = valid_q;
  assign adel_F  = adel_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a zero-wait memory returning addr^A5A5_0000.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins_F;
  logic [31:0] pc_F;
  logic        valid_F;
  logic        adel_F;

  int errors = 0;
  int checks = 0;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ins_F      (ins_F),
    .pc_F       (pc_F),
    .valid_F    (valid_F),
    .adel_F     (adel_F)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Check the whole buffer plus the request signals
  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pcf, input logic [31:0] ins,
                         input logic adel);
    chk({tag, ".req"}, 32'(imem_req), 32'(req));
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, 32'(valid_F), 32'(v));
    chk({tag, ".pc_F"}, pc_F, pcf);
    chk({tag, ".ins_F"}, ins_F, ins);
    chk({tag, ".adel"}, 32'(adel_F), 32'(adel));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    go(); go();
    #1 chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    rst = 1'b0;
    #1 chk_all("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("boot.addr", imem_addr, 32'h0000_3000);
    go(); #1 chk_all("run0", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
    go(); #1 chk_all("f3000", 1'b1, 32'h3004, 1'b1, 32'h3000, 32'hA5A5_3000, 1'b0);
    go(); #1 chk_all("f3004", 1'b1, 32'h3008, 1'b1, 32'h3004, 32'hA5A5_3004, 1'b0);

    // Memory wait of three cycles at 0x3008
    imem_ready = 1'b0;
    go(); #1 chk_all("wait1", 1'b1, 32'h3008, 1'b0, 32'h3004, 32'h0, 1'b0);
    go(); #1 chk_all("wait2", 1'b1, 32'h3008, 1'b0, 32'h3004, 32'h0, 1'b0);
    go(); imem_ready = 1'b1;
    #1 chk_all("wait3", 1'b1, 32'h3008, 1'b0, 32'h3004, 32'h0, 1'b0);
    go(); #1 chk_all("f3008", 1'b1, 32'h300C, 1'b1, 32'h3008, 32'hA5A5_3008, 1'b0);
    go();

    // Stall four cycles with a full buffer
    stall = 1'b1;
    #1 chk_all("stall0", 1'b0, 32'h0, 1'b1, 32'h300C, 32'hA5A5_300C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      go();
      if (i == 3) stall = 1'b0;
      #1;
      if (i < 3) chk_all("stall", 1'b0, 32'h0, 1'b1, 32'h300C, 32'hA5A5_300C, 1'b0);
    end
    chk_all("unstall", 1'b1, 32'h3010, 1'b1, 32'h300C, 32'hA5A5_300C, 1'b0);
    go(); #1 chk_all("f3010", 1'b1, 32'h3014, 1'b1, 32'h3010, 32'hA5A5_3010, 1'b0);

    // Redirect while stalled, full buffer, memory mid-wait
    stall = 1'b1; imem_ready = 1'b0;
    go();
    redirect = 1'b1; redirect_pc = 32'h0000_4000; imem_ready = 1'b1;
    #1 chk("redir.req", 32'(imem_req), 32'h0);
    go();
    redirect = 1'b0; stall = 1'b0;
    #1 chk_all("flush", 1'b1, 32'h4000, 1'b0, 32'h3010, 32'h0, 1'b0);
    go(); #1 chk_all("f4000", 1'b1, 32'h4004, 1'b1, 32'h4000, 32'hA5A5_4000, 1'b0);
    go(); #1 chk_all("f4004", 1'b1, 32'h4008, 1'b1, 32'h4004, 32'hA5A5_4004, 1'b0);

    // Misaligned redirect parks with an ADEL entry
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    go(); redirect = 1'b0;
    #1 chk_all("mis.flush", 1'b0, 32'h0, 1'b0, 32'h4004, 32'h0, 1'b0);
    go(); #1 chk_all("adel1", 1'b0, 32'h0, 1'b1, 32'h4002, 32'h0, 1'b1);
    go(); #1 chk_all("adel2", 1'b0, 32'h0, 1'b1, 32'h4002, 32'h0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    go(); redirect = 1'b0;
    #1 chk_all("resume", 1'b1, 32'h3000, 1'b0, 32'h4002, 32'h0, 1'b0);
    go(); #1 chk_all("r3000", 1'b1, 32'h3004, 1'b1, 32'h3000, 32'hA5A5_3000, 1'b0);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    go(); redirect = 1'b0;
    #1 chk_all("wrap.flush", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h3000, 32'h0, 1'b0);
    go(); #1 chk_all("wFFF8", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'h5A5A_FFF8, 1'b0);
    go(); #1 chk_all("wFFFC", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b0);
    go(); #1 chk_all("w0000", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b0);

    // Reset during a memory wait drops the request
    imem_ready = 1'b0;
    go(); rst = 1'b1;
    #1 chk("rstw.req", 32'(imem_req), 32'h0);
    go(); rst = 1'b0; imem_ready = 1'b1;
    #1 chk_all("rstw", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rstw.addr", imem_addr, 32'h0000_3000);
    go(); go(); #1 chk_all("rstw.f", 1'b1, 32'h3004, 1'b1, 32'h3000, 32'hA5A5_3000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end that owns the program counter, issues word requests to instruction memory over a ready/request handshake, and presents fetched instruction/PC pairs to the IF/ID pipeline register through a one-entry output buffer. It is the producer side of the `ins_F`/`pc_F` interface. It honours the pipeline stall (IF/ID hold) and accepts branch/jump/exception redirects from later stages. It sits between `imem` and `IF_ID` in the p6 pipeline.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  high means IF/ID is holding this cycle; the buffer entry is not consumed.
- `redirect`  in  1  single-cycle pulse to change the fetch stream.
- `redirect_pc`  in  32  new fetch address, valid when `redirect`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of the request; equals `pc_reg`.
- `imem_ready`  in  1  request accepted; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `ins_F`  out  32  buffered instruction; 0 (nop) when `valid_F`=0.
- `pc_F`  out  32  address of `ins_F`. IF_ID adds 4 to it.
- `valid_F`  out  1  output buffer holds a live instruction.
- `adel_F`  out  1  buffered entry came from a misaligned redirect.

## Operation
- State: `pc_reg` (next fetch address), the output buffer (`ins_F`, `pc_F`, `valid_F`, `adel_F`), and FSM `st` ∈ {BOOT, RUN}.
- Reset: `pc_reg`=RESET_PC, `st`=BOOT, `ins_F`=0, `pc_F`=0, `valid_F`=0, `adel_F`=0. `imem_req` is 0 during reset.
- BOOT lasts exactly one cycle with `imem_req`=0, then moves to RUN. RUN has no exit except `rst`.
- Drain: the buffer is consumed at an edge where `valid_F`=1 and `stall`=0.
- Room: `room` = !`valid_F` | !`stall`. This is combinational on `stall`.
- Request rules in RUN:
  - `imem_req` = `room` & !`redirect` & !`misal`.
  - A request is non-binding until the cycle in which `imem_req`&`imem_ready`=1 (a fire). Before that, the address may change.
- Fire: at the edge, `ins_F`<=`imem_rdata`, `pc_F`<=`pc_reg`, `valid_F`<=1, `adel_F`<=0, and `pc_reg`<=`pc_reg`+4 (mod 2^32, wraps FFFF_FFFC→0).
- Drain without fire: `valid_F`<=0 and `ins_F`<=0. `pc_F` holds its value.
- Redirect (highest priority after `rst`, and overrides `stall`):
  - Buffer is flushed: `valid_F`<=0, `ins_F`<=0.
  - `pc_reg`<=`redirect_pc`.
  - Any `imem_ready` in the same cycle is ignored, because `imem_req` is 0.
- Misaligned PC: `misal` = `pc_reg`[1:0]≠0, which only a redirect can cause.
  - In RUN with `room`: no memory request. Instead the buffer loads `ins_F`=0, `pc_F`=`pc_reg`, `valid_F`=1, `adel_F`=1, and `pc_reg` holds.
  - The block then stays parked until a redirect, re-issuing the same ADEL entry each time the buffer drains.
- Redirect during BOOT: `pc_reg` is updated and BOOT still completes.

## Timing
- Zero-wait memory, no stall: one instruction per cycle. `valid_F` rises at the second edge after `rst` falls (one edge in BOOT, the first fire at the next).
- Latency from a fire to IF/ID capture is one edge (the buffer edge). From a redirect edge to the first new-path `valid_F` is one edge plus the memory wait.
- Stall with a full buffer: `imem_req`=0, and the buffer and `pc_reg` are stable for the whole stall.
- Stall with an empty buffer: one fetch may complete. The buffer then fills, and requests stop.
- `stall` and `redirect` together: the redirect wins and the buffer is flushed.
- `rst` mid-wait: the outstanding non-binding request is dropped with no other effect.
- Every output register changes only on `clk` rising edges. `imem_req` and `imem_addr` are combinational from state, `stall` and `redirect`.

## Test plan
- Reset then zero-wait memory returning addr^32'hA5A5_0000:
  - Cycle 0 after reset: `imem_req`=0.
  - Then `imem_addr`=3000, 3004, 3008.
  - `pc_F`/`ins_F` follow one cycle behind, with `valid_F`=1 continuously.
- `imem_ready` low for 3 cycles at 0x3008:
  - `imem_addr` holds at 3008.
  - `valid_F`=0 for the gap after the buffer drains.
  - Then `ins_F` = the 3008 word and `pc_F`=3008.
- `stall` for 4 cycles with a full buffer (`pc_F`=300C):
  - `imem_req`=0.
  - `pc_F`/`ins_F` are stable.
  - After release the next address is 3010, with no duplicate and no skip.
- Redirect to 0x0000_4000 while stalled with a full buffer and the memory mid-wait:
  - Next edge: `valid_F`=0, `ins_F`=0.
  - Then fetches 4000, 4004.
  - The stale response is never buffered.
- Redirect to 0x0000_4002:
  - Produces `valid_F`=1, `adel_F`=1, `pc_F`=4002, `ins_F`=0, with no `imem_req`.
  - A later redirect to 0x3000 resumes normal fetch with `adel_F`=0.
- Redirect to FFFF_FFF8 with zero-wait memory: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
